invader_formation: RTL and testbench



---
 rtl/invader_formation.sv | 219 +++++++++++++++++++++
 tb/tb_invader_formation.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/invader_formation.sv
// Formation engine: owns alive mask, origin, march direction and step pacing; resolves hits by a per-frame scan.
// Optional macro INVADER_SPEEDUP_EN: step period tracks the alive count instead of the constant FRAME_DIV.
module invader_formation #(
   parameter int NUM_ROWS          = 3,
   parameter int NUM_COLS          = 10,
   parameter int INVADER_WIDTH     = 64,
   parameter int INVADER_HEIGHT    = 32,
   parameter int COL_PITCH         = 100,
   parameter int ROW_PITCH         = 100,
   parameter int X_INIT            = 0,
   parameter int Y_INIT            = 100,
   parameter int STEP_X            = 4,
   parameter int STEP_Y            = 16,
   parameter int FRAME_DIV         = 8,
   parameter int SPEED_SHIFT       = 2,
   parameter int HOR_PIXELS        = 1024,
   parameter int LAND_Y            = 704,
   parameter int PROJECTILE_WIDTH  = 16,
   parameter int PROJECTILE_HEIGHT = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             frame_tick,
   input  logic                             restart,
   input  logic [11:0]                      projectile_xpos,
   input  logic [11:0]                      projectile_ypos,
   input  logic                             bullet_active,
   output logic [11:0]                      form_xpos,
   output logic [11:0]                      form_ypos,
   output logic [NUM_ROWS*NUM_COLS-1:0]     alive,
   output logic                             bullet_hit,
   output logic [$clog2(NUM_ROWS)-1:0]      hit_row,
   output logic [$clog2(NUM_COLS)-1:0]      hit_col,
   output logic [15:0]                      score,
   output logic                             wave_clear,
   output logic                             landed
);
   localparam int N       = NUM_ROWS * NUM_COLS;
   localparam int IW      = $clog2(N + 1);
   localparam int RW      = $clog2(NUM_ROWS);
   localparam int CW      = $clog2(NUM_COLS);
   localparam int CNTW    = $clog2(N + 1);
   localparam int SPD_MAX = (N >> SPEED_SHIFT) + 1;
   localparam int MAXP    = (FRAME_DIV > SPD_MAX) ? FRAME_DIV : SPD_MAX;
   localparam int FW      = $clog2(MAXP + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_UPDATE,
      S_CLEAR,
      S_LANDED
   } state_t;

   state_t          state, state_next;
   logic [IW-1:0]   idx, match_idx;
   logic [RW-1:0]   scan_r, match_r, maxr;
   logic [CW-1:0]   scan_c, match_c, minc, maxc;
   logic [CNTW-1:0] acnt;
   logic            match_vld;
   logic            dir_right;
   logic [FW-1:0]   fcnt, period;
   logic [12:0]     inv_x, inv_y, prj_x, prj_y;
   logic [12:0]     right_edge, left_edge, bottom_edge;
   logic            overlap, hit_now, last_idx;
   logic            rev_right, rev_left, reach_land, post_empty, step_now;
   logic [N-1:0]    alive_post;

   // Geometry is 13 bits wide so sums of 12-bit positions and offsets never wrap.
   assign inv_x = 13'(form_xpos) + 13'(scan_c) * 13'(COL_PITCH);
   assign inv_y = 13'(form_ypos) + 13'(scan_r) * 13'(ROW_PITCH);
   assign prj_x = 13'(projectile_xpos);
   assign prj_y = 13'(projectile_ypos);

   assign overlap = (inv_x < prj_x + 13'(PROJECTILE_WIDTH))  && (prj_x < inv_x + 13'(INVADER_WIDTH)) &&
                    (inv_y < prj_y + 13'(PROJECTILE_HEIGHT)) && (prj_y < inv_y + 13'(INVADER_HEIGHT));
   assign hit_now  = bullet_active && alive[idx] && overlap && !match_vld;
   assign last_idx = (idx == IW'(N - 1));

   assign right_edge  = 13'(form_xpos) + 13'(maxc) * 13'(COL_PITCH) + 13'(INVADER_WIDTH + STEP_X);
   assign left_edge   = 13'(form_xpos) + 13'(minc) * 13'(COL_PITCH);
   assign bottom_edge = 13'(form_ypos) + 13'(maxr) * 13'(ROW_PITCH) + 13'(INVADER_HEIGHT);
   assign rev_right   = right_edge > 13'(HOR_PIXELS);
   assign rev_left    = left_edge < 13'(STEP_X);
   assign reach_land  = bottom_edge >= 13'(LAND_Y);

   // The latched match always refers to a live invader, so one kill leaves acnt-1 alive.
   assign post_empty = (acnt == CNTW'(0)) || (match_vld && (acnt == CNTW'(1)));

`ifdef INVADER_SPEEDUP_EN
   assign period = FW'(acnt >> SPEED_SHIFT) + FW'(1);
`else
   assign period = FW'(FRAME_DIV);
`endif
   assign step_now = (fcnt >= period - FW'(1));

   always_comb begin
      alive_post = alive;
      if (match_vld) alive_post[match_idx] = 1'b0;
   end

   assign wave_clear = (state == S_CLEAR);
   assign landed     = (state == S_LANDED);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (frame_tick) state_next = S_SCAN;
         S_SCAN:   if (last_idx) state_next = S_UPDATE;
         S_UPDATE: begin
            if (post_empty)      state_next = S_CLEAR;
            else if (reach_land) state_next = S_LANDED;
            else                 state_next = S_IDLE;
         end
         S_CLEAR, S_LANDED: if (restart) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         form_xpos  <= 12'(X_INIT);
         form_ypos  <= 12'(Y_INIT);
         alive      <= '1;
         dir_right  <= 1'b1;
         fcnt       <= '0;
         score      <= '0;
         bullet_hit <= 1'b0;
         hit_row    <= '0;
         hit_col    <= '0;
         idx        <= '0;
         scan_r     <= '0;
         scan_c     <= '0;
         match_vld  <= 1'b0;
         match_idx  <= '0;
         match_r    <= '0;
         match_c    <= '0;
         minc       <= '0;
         maxc       <= '0;
         maxr       <= '0;
         acnt       <= '0;
      end else begin
         bullet_hit <= 1'b0;
         case (state)
            S_IDLE: begin
               if (frame_tick) begin
                  idx       <= '0;
                  scan_r    <= '0;
                  scan_c    <= '0;
                  match_vld <= 1'b0;
                  minc      <= CW'(NUM_COLS - 1);
                  maxc      <= '0;
                  maxr      <= '0;
                  acnt      <= '0;
               end
            end
            S_SCAN: begin
               if (hit_now) begin
                  match_vld <= 1'b1;
                  match_idx <= idx;
                  match_r   <= scan_r;
                  match_c   <= scan_c;
               end
               if (alive[idx]) begin
                  acnt <= acnt + CNTW'(1);
                  if (scan_c < minc) minc <= scan_c;
                  if (scan_c > maxc) maxc <= scan_c;
                  if (scan_r > maxr) maxr <= scan_r;
               end
               idx <= idx + IW'(1);
               if (scan_c == CW'(NUM_COLS - 1)) begin
                  scan_c <= '0;
                  scan_r <= scan_r + RW'(1);
               end else begin
                  scan_c <= scan_c + CW'(1);
               end
            end
            S_UPDATE: begin
               alive <= alive_post;
               if (match_vld) begin
                  bullet_hit <= 1'b1;
                  hit_row    <= match_r;
                  hit_col    <= match_c;
                  if (score != 16'hFFFF) score <= score + 16'd1;
               end
               if (step_now) begin
                  fcnt <= '0;
                  if (dir_right ? rev_right : rev_left) begin
                     dir_right <= !dir_right;
                     form_ypos <= form_ypos + 12'(STEP_Y);
                  end else if (dir_right) begin
                     form_xpos <= form_xpos + 12'(STEP_X);
                  end else begin
                     form_xpos <= form_xpos - 12'(STEP_X);
                  end
               end else begin
                  fcnt <= fcnt + FW'(1);
               end
            end
            S_CLEAR, S_LANDED: begin
               if (restart) begin
                  form_xpos <= 12'(X_INIT);
                  form_ypos <= 12'(Y_INIT);
                  alive     <= '1;
                  dir_right <= 1'b1;
                  fcnt      <= '0;
                  if (state == S_LANDED) score <= '0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_invader_formation.sv
// Directed bench for invader_formation: hand-computed positions, kills, clear/land and reset behaviour.
module tb_invader_formation;
   // Landing line lowered to 400 so a landing needs 5 drops instead of 24 (landing at form_ypos >= 168).
   localparam int LAND = 400;
   localparam logic [29:0] ALL = 30'h3FFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_tick = 1'b0;
   logic        restart = 1'b0;
   logic [11:0] projectile_xpos = '0;
   logic [11:0] projectile_ypos = '0;
   logic        bullet_active = 1'b0;
   logic [11:0] form_xpos, form_ypos;
   logic [29:0] alive;
   logic        bullet_hit;
   logic [1:0]  hit_row;
   logic [3:0]  hit_col;
   logic [15:0] score;
   logic        wave_clear, landed;

   int n_assert = 0;
   int n_fail   = 0;
   int hits     = 0;
   int hit_at   = 0;

   invader_formation #(.LAND_Y(LAND)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .restart(restart),
      .projectile_xpos(projectile_xpos), .projectile_ypos(projectile_ypos),
      .bullet_active(bullet_active), .form_xpos(form_xpos), .form_ypos(form_ypos),
      .alive(alive), .bullet_hit(bullet_hit), .hit_row(hit_row), .hit_col(hit_col),
      .score(score), .wave_clear(wave_clear), .landed(landed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One frame: tick sampled at edge 0, then 31 more edges so the DUT is back in IDLE.
   task automatic frame();
      frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
      hits = 0;
      hit_at = 0;
      for (int k = 1; k <= 31; k++) begin
         @(posedge clk); #1;
         if (bullet_hit === 1'b1) begin
            hits++;
            hit_at = k;
         end
      end
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(posedge clk); #1 restart = 1'b0;
   endtask

   task automatic aim(input int x, input int y);
      projectile_xpos = 12'(x);
      projectile_ypos = 12'(y);
   endtask

   initial begin
      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_x", form_xpos, 0);
      chk("rst_y", form_ypos, 100);
      chk("rst_alive", alive, ALL);
      chk("rst_score", score, 0);
      chk("rst_hit", bullet_hit, 0);
      chk("rst_hit_row", hit_row, 0);
      chk("rst_hit_col", hit_col, 0);
      chk("rst_clear", wave_clear, 0);
      chk("rst_landed", landed, 0);
      rst = 1'b0;

      // Pacing: first step on the 8th frame, then march right to the edge
      frames(7);
      chk("x_after7", form_xpos, 0);
      frame();
      chk("x_after8", form_xpos, 4);
      chk("alive_after8", alive, ALL);
      chk("score_after8", score, 0);
      frames(112);
      chk("x_step15", form_xpos, 60);
      chk("y_step15", form_ypos, 100);
      frames(8);
      chk("x_reverse", form_xpos, 60);
      chk("y_reverse", form_ypos, 116);
      frames(8);
      chk("x_left", form_xpos, 56);
      chk("y_left", form_ypos, 116);

      // Single kill: pulse timing relative to the tick
      pulse_rst();
      aim(20, 100);
      bullet_active = 1'b1;
      frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
      repeat (30) @(posedge clk);
      #1 chk("hit_cycle31", bullet_hit, 0);
      @(posedge clk); #1;
      chk("hit_cycle32", bullet_hit, 1);
      chk("hit_row0", hit_row, 0);
      chk("hit_col0", hit_col, 0);
      chk("alive_kill0", alive, ALL & ~30'h1);
      chk("score_kill0", score, 1);
      @(posedge clk); #1;
      chk("hit_cycle33", bullet_hit, 0);
      frame();
      chk("no_rehit", hits, 0);
      chk("score_no_rehit", score, 1);

      // Kill column 9 in each row, then march: reversal uses maxc=8
      pulse_rst();
      for (int r = 0; r < 3; r++) begin
         aim(924, 100 + r * 100);
         frame();
         chk("col9_hits", hits, 1);
         chk("col9_hit_at", hit_at, 31);
      end
      chk("col9_alive", alive, ALL & ~((30'h1 << 9) | (30'h1 << 19) | (30'h1 << 29)));
      chk("col9_row", hit_row, 2);
      chk("col9_col", hit_col, 9);
      chk("col9_score", score, 3);
      bullet_active = 1'b0;
      frames(317);
      chk("col9_x160", form_xpos, 160);
      chk("col9_y100", form_ypos, 100);
      frames(8);
      chk("col9_rev_x", form_xpos, 160);
      chk("col9_rev_y", form_ypos, 116);

      // Kill all 30 from reset; projectile sits 24 px into the target column
      pulse_rst();
      bullet_active = 1'b1;
      for (int i = 0; i < 30; i++) begin
         aim((i % 10) * 100 + 24, 100 + (i / 10) * 100);
         frame();
         chk("killall_hit", hits, 1);
      end
      chk("clear_flag", wave_clear, 1);
      chk("clear_alive", alive, 0);
      chk("clear_score", score, 30);
      chk("clear_x", form_xpos, 12);
      chk("clear_y", form_ypos, 100);
      chk("clear_landed", landed, 0);
      bullet_active = 1'b0;
      frames(2);
      chk("clear_frozen_x", form_xpos, 12);
      chk("clear_frozen_flag", wave_clear, 1);
      chk("clear_no_pulse", hits, 0);
      pulse_restart();
      chk("restart_alive", alive, ALL);
      chk("restart_x", form_xpos, 0);
      chk("restart_y", form_ypos, 100);
      chk("restart_score", score, 30);
      chk("restart_clear", wave_clear, 0);

      // March to landing: 5th drop at frame 640 gives y=180, landed on frame 641
      frames(640);
      chk("pre_land_flag", landed, 0);
      chk("pre_land_y", form_ypos, 180);
      chk("pre_land_x", form_xpos, 60);
      frame();
      chk("land_flag", landed, 1);
      chk("land_y", form_ypos, 180);
      chk("land_score", score, 30);
      frames(2);
      chk("land_frozen_x", form_xpos, 60);
      chk("land_frozen_y", form_ypos, 180);
      chk("land_frozen_flag", landed, 1);
      pulse_restart();
      chk("land_restart_flag", landed, 0);
      chk("land_restart_score", score, 0);
      chk("land_restart_x", form_xpos, 0);
      chk("land_restart_y", form_ypos, 100);

      // Kill r1/c2, then reset in the middle of a scan
      bullet_active = 1'b1;
      aim(224, 200);
      frame();
      chk("mid_prekill_hits", hits, 1);
      chk("mid_prekill_row", hit_row, 1);
      chk("mid_prekill_col", hit_col, 2);
      chk("mid_prekill_score", score, 1);
      aim(20, 100);
      frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
      repeat (10) @(posedge clk);
      #1 pulse_rst();
      chk("mid_rst_x", form_xpos, 0);
      chk("mid_rst_y", form_ypos, 100);
      chk("mid_rst_alive", alive, ALL);
      chk("mid_rst_score", score, 0);
      chk("mid_rst_row", hit_row, 0);
      chk("mid_rst_col", hit_col, 0);
      chk("mid_rst_hit", bullet_hit, 0);
      hits = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (bullet_hit === 1'b1) hits++;
      end
      chk("mid_rst_no_pulse", hits, 0);
      chk("mid_rst_alive_after", alive, ALL);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
